// File: rtl/eth_pkg.sv
// Shared Ethernet TX constants: AXI-Stream widths and packet-FIFO FSM encodings.
package eth_pkg;

    localparam int AXIS_DATA_W    = 64;
    localparam int AXIS_KEEP_W    = AXIS_DATA_W / 8;
    localparam int PKTFIFO_ADDR_W = 9;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_WRITE   = 2'd1,
        WR_DISCARD = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        RD_IDLE  = 2'd0,
        RD_FETCH = 2'd1,
        RD_SEND  = 2'd2
    } rd_state_e;

endpackage

// File: rtl/eth_pktfifo_ram.sv
// Simple dual-port frame buffer RAM with a one-cycle registered read port.
module eth_pktfifo_ram #(
    parameter int WIDTH      = 73,
    parameter int ADDR_WIDTH = 9
) (
    input  logic                  clk_i,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_en_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic [WIDTH-1:0]      rd_data_o
);

    logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [WIDTH-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Read port; output holds its value when no read is issued
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/eth_tx_pktfifo.sv
// Store-and-forward TX packet FIFO between eth_encap and the 10G MAC.
// Define ETH_TX_PKTFIFO_STATS_EN to build the frame/drop statistics counters.
module eth_tx_pktfifo
    import eth_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_W,
    parameter int ADDR_WIDTH = PKTFIFO_ADDR_W
) (
    input  logic                    clk156,
    input  logic                    eth_rst,
    input  logic                    s_axis_tvalid,
    output logic                    s_axis_tready,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                    s_axis_tlast,
    input  logic                    s_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic                    m_axis_tuser,
    output logic [31:0]             stat_frames,
    output logic [31:0]             stat_drops
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int WORD_W = DATA_WIDTH + KEEP_W + 1;
    localparam int CNT_W  = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
    localparam logic [CNT_W-1:0]      CNT_ONE = CNT_W'(1);

    wr_state_e             wr_state_q, wr_state_d;
    rd_state_e             rd_state_q, rd_state_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, start_ptr_q, start_ptr_d, frame_start_s;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      frame_cnt_q;
    logic                  full_s, wr_en_s, commit_s, fetch_s, load_s, rd_en_s, sent_s;
    logic [WORD_W-1:0]     wr_word_s, rd_word_s;
    logic                  out_valid_q, out_valid_d, out_last_q, out_last_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [KEEP_W-1:0]     out_keep_q, out_keep_d;

    assign full_s        = (wr_ptr_q + PTR_ONE) == rd_ptr_q;
    assign wr_en_s       = s_axis_tvalid && !eth_rst && (wr_state_q != WR_DISCARD) && !full_s;
    assign frame_start_s = (wr_state_q == WR_IDLE) ? wr_ptr_q : start_ptr_q;
    assign wr_word_s     = {s_axis_tlast, s_axis_tkeep, s_axis_tdata};

    eth_pktfifo_ram #(
        .WIDTH      (WORD_W),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk_i     (clk156),
        .wr_en_i   (wr_en_s),
        .wr_addr_i (wr_ptr_q),
        .wr_data_i (wr_word_s),
        .rd_en_i   (rd_en_s),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (rd_word_s)
    );

    // Write side: accept every beat, commit good frames, rewind on error or overflow
    always_comb begin
        wr_state_d  = wr_state_q;
        wr_ptr_d    = wr_ptr_q;
        start_ptr_d = start_ptr_q;
        commit_s    = 1'b0;
        if (s_axis_tvalid) begin
            start_ptr_d = frame_start_s;
            if (s_axis_tlast) begin
                wr_state_d = WR_IDLE;
                if (wr_en_s && !s_axis_tuser) begin
                    wr_ptr_d = wr_ptr_q + PTR_ONE;
                    commit_s = 1'b1;
                end else begin
                    wr_ptr_d = frame_start_s;
                end
            end else if (wr_en_s) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                wr_state_d = WR_WRITE;
            end else begin
                wr_state_d = WR_DISCARD;
            end
        end else begin
            wr_state_d = wr_state_q;
        end
    end

    // Read side: the RAM output always holds the word after the one being presented,
    // so each accepted beat is refilled in the same cycle and a frame never stalls.
    assign fetch_s  = (rd_state_q == RD_IDLE) && (frame_cnt_q != '0);
    assign rd_en_s  = fetch_s || (load_s && !rd_word_s[WORD_W-1]);
    assign rd_ptr_d = rd_en_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    // Read FSM next state and output-register loading
    always_comb begin
        rd_state_d  = rd_state_q;
        load_s      = 1'b0;
        sent_s      = 1'b0;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_keep_d  = out_keep_q;
        out_last_d  = out_last_q;
        case (rd_state_q)
            RD_IDLE: begin
                rd_state_d = fetch_s ? RD_FETCH : RD_IDLE;
            end
            RD_FETCH: begin
                load_s     = 1'b1;
                rd_state_d = RD_SEND;
            end
            RD_SEND: begin
                if (out_valid_q && m_axis_tready) begin
                    if (out_last_q) begin
                        out_valid_d = 1'b0;
                        sent_s      = 1'b1;
                        rd_state_d  = RD_IDLE;
                    end else begin
                        load_s = 1'b1;
                    end
                end else begin
                    rd_state_d = RD_SEND;
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
        if (load_s) begin
            out_valid_d = 1'b1;
            out_data_d  = rd_word_s[DATA_WIDTH-1:0];
            out_keep_d  = rd_word_s[DATA_WIDTH +: KEEP_W];
            out_last_d  = rd_word_s[WORD_W-1];
        end else begin
            out_last_d = out_last_d;
        end
    end

    // State, pointer and committed-frame-count registers
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            wr_state_q  <= WR_IDLE;
            rd_state_q  <= RD_IDLE;
            wr_ptr_q    <= '0;
            start_ptr_q <= '0;
            rd_ptr_q    <= '0;
            frame_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_keep_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_ptr_q    <= wr_ptr_d;
            start_ptr_q <= start_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_keep_q  <= out_keep_d;
            out_last_q  <= out_last_d;
            case ({commit_s, sent_s})
                2'b10:   frame_cnt_q <= frame_cnt_q + CNT_ONE;
                2'b01:   frame_cnt_q <= frame_cnt_q - CNT_ONE;
                default: frame_cnt_q <= frame_cnt_q;
            endcase
        end
    end

    // Reset forces the outputs low immediately rather than one edge later
    assign s_axis_tready = !eth_rst;
    assign m_axis_tvalid = out_valid_q && !eth_rst;
    assign m_axis_tdata  = eth_rst ? '0 : out_data_q;
    assign m_axis_tkeep  = eth_rst ? '0 : out_keep_q;
    assign m_axis_tlast  = out_last_q && !eth_rst;
    assign m_axis_tuser  = 1'b0;

`ifdef ETH_TX_PKTFIFO_STATS_EN
    logic        drop_s;
    logic [31:0] stat_frames_q, stat_drops_q;

    // Every accepted final beat that does not commit ends a dropped frame
    assign drop_s = s_axis_tvalid && !eth_rst && s_axis_tlast && !commit_s;

    // Statistics counters, free-running with natural wrap
    always_ff @(posedge clk156) begin
        if (eth_rst) begin
            stat_frames_q <= 32'd0;
            stat_drops_q  <= 32'd0;
        end else begin
            stat_frames_q <= stat_frames_q + {31'd0, commit_s};
            stat_drops_q  <= stat_drops_q + {31'd0, drop_s};
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_drops  = stat_drops_q;
`else
    assign stat_frames = 32'd0;
    assign stat_drops  = 32'd0;
`endif

endmodule

// File: tb/tb_eth_tx_pktfifo.sv
// Self-checking bench for eth_tx_pktfifo: frame-level model plus per-cycle output checker.
module tb_eth_tx_pktfifo;

    localparam int DW  = 64;
    localparam int KW  = DW / 8;
    localparam int CAP = 511;

    logic          clk156;
    logic          eth_rst;
    logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
    logic [DW-1:0] s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic [31:0]   stat_frames, stat_drops;

    int checks = 0;
    int errors = 0;
    logic [DW+KW:0] exp_q[$];
    logic [DW+KW:0] w;
    int out_beats = 0;
    logic [DW-1:0] last_data_seen;
    logic [KW-1:0] last_keep_seen;
    int model_frames = 0;
    int model_drops  = 0;
    logic toggle_en = 1'b0;
    logic prev_stall = 1'b0;
    logic in_frame = 1'b0;
    logic [DW-1:0] prev_data;
    logic [KW-1:0] prev_keep;
    logic prev_last;

    eth_tx_pktfifo dut (
        .clk156        (clk156),
        .eth_rst       (eth_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .stat_frames   (stat_frames),
        .stat_drops    (stat_drops)
    );

    initial begin
        clk156 = 1'b0;
        forever #5 clk156 = ~clk156;
    end

    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk156);
            #1;
            if (toggle_en) m_axis_tready = ~m_axis_tready;
            else m_axis_tready = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mk(input int id, input int b);
        return {16'(id), 16'h0000, 32'(b)};
    endfunction

    // Output checker: ordering vs model, stability during stalls, no gaps, reset values
    always @(negedge clk156) begin
        if (eth_rst) begin
            chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
            chk("rst_m_tdata", m_axis_tdata, 64'd0);
            chk("rst_m_tkeep", 64'(m_axis_tkeep), 64'd0);
            chk("rst_m_tlast", 64'(m_axis_tlast), 64'd0);
            chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
            prev_stall = 1'b0;
            in_frame   = 1'b0;
        end else begin
            chk("s_tready", 64'(s_axis_tready), 64'd1);
            if (prev_stall) begin
                chk("stall_tvalid", 64'(m_axis_tvalid), 64'd1);
                chk("stall_tdata", m_axis_tdata, prev_data);
                chk("stall_tkeep", 64'(m_axis_tkeep), 64'(prev_keep));
                chk("stall_tlast", 64'(m_axis_tlast), 64'(prev_last));
            end else if (in_frame) begin
                chk("gap_tvalid", 64'(m_axis_tvalid), 64'd1);
            end
            if (m_axis_tvalid) begin
                chk("m_tuser", 64'(m_axis_tuser), 64'd0);
                if (m_axis_tready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat: got data %0h, want no output", m_axis_tdata);
                    end else begin
                        w = exp_q.pop_front();
                        chk("out_tdata", m_axis_tdata, w[DW-1:0]);
                        chk("out_tkeep", 64'(m_axis_tkeep), 64'(w[DW +: KW]));
                        chk("out_tlast", 64'(m_axis_tlast), 64'(w[DW+KW]));
                    end
                    out_beats++;
                    last_data_seen = m_axis_tdata;
                    last_keep_seen = m_axis_tkeep;
                    in_frame = !m_axis_tlast;
                end else begin
                    in_frame = 1'b1;
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
            prev_keep  = m_axis_tkeep;
            prev_last  = m_axis_tlast;
        end
    end

    task automatic send_frame(input int id, input int len, input logic [KW-1:0] lkeep, input logic user);
        logic commit;
        commit = !user && (len <= CAP - exp_q.size());
        for (int b = 0; b < len; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mk(id, b);
            s_axis_tkeep  = (b == len - 1) ? lkeep : 8'hFF;
            s_axis_tlast  = (b == len - 1);
            s_axis_tuser  = (b == len - 1) ? user : 1'b0;
            @(posedge clk156);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        if (commit) begin
            for (int b = 0; b < len; b++) begin
                exp_q.push_back({(b == len - 1), (b == len - 1) ? lkeep : 8'hFF, mk(id, b)});
            end
            model_frames++;
        end else begin
            model_drops++;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || m_axis_tvalid) && n < 3000) begin
            @(posedge clk156);
            #1;
            n++;
        end
        chk("drain_in_time", 64'(n < 3000), 64'd1);
        repeat (5) @(posedge clk156);
        #1;
    endtask

    task automatic chk_stats();
`ifdef ETH_TX_PKTFIFO_STATS_EN
        chk("stat_frames", 64'(stat_frames), 64'(model_frames));
        chk("stat_drops", 64'(stat_drops), 64'(model_drops));
`else
        chk("stat_frames_tied", 64'(stat_frames), 64'd0);
        chk("stat_drops_tied", 64'(stat_drops), 64'd0);
`endif
    endtask

    initial begin
        int base;
        int lat;
        eth_rst       = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tdata  = '0;
        s_axis_tkeep  = '0;
        s_axis_tlast  = 1'b0;
        s_axis_tuser  = 1'b0;
        repeat (3) @(posedge clk156);
        #1;
        eth_rst = 1'b0;
        @(posedge clk156);
        #1;
        chk("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk_stats();

        // Single 8-beat frame, latency and content
        base = out_beats;
        send_frame(1, 8, 8'h0F, 1'b0);
        lat = 0;
        while (!m_axis_tvalid && lat < 20) begin
            @(posedge clk156);
            #1;
            lat++;
        end
        chk("commit_to_tvalid_latency", 64'(lat), 64'd2);
        drain();
        chk("t1_beats", 64'(out_beats - base), 64'd8);
        chk("t1_last_data", last_data_seen, 64'h0001_0000_0000_0007);
        chk("t1_last_keep", 64'(last_keep_seen), 64'h0F);
`ifdef ETH_TX_PKTFIFO_STATS_EN
        chk("t1_stat_frames_lit", 64'(stat_frames), 64'd1);
`endif
        chk_stats();

        // Errored frame dropped
        base = out_beats;
        send_frame(2, 8, 8'hFF, 1'b1);
        repeat (20) @(posedge clk156);
        #1;
        chk("t2_no_output", 64'(out_beats - base), 64'd0);
        chk_stats();

        // Oversize frame overflows and is dropped; next frame intact
        base = out_beats;
        send_frame(3, 600, 8'hFF, 1'b0);
        send_frame(4, 4, 8'h3F, 1'b0);
        drain();
        chk("t3_beats", 64'(out_beats - base), 64'd4);
        chk("t3_last_data", last_data_seen, 64'h0004_0000_0000_0003);
        chk_stats();

        // Back-to-back frames with a toggling sink
        base = out_beats;
        toggle_en = 1'b1;
        send_frame(5, 64, 8'hFF, 1'b0);
        send_frame(6, 64, 8'h01, 1'b0);
        send_frame(7, 64, 8'h7F, 1'b0);
        drain();
        toggle_en = 1'b0;
        repeat (2) @(posedge clk156);
        #1;
        chk("t4_beats", 64'(out_beats - base), 64'd192);
        chk("t4_last_data", last_data_seen, 64'h0007_0000_0000_003F);
        chk_stats();

        // Reset pulse in the middle of an input frame
        for (int b = 0; b < 3; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = mk(8, b);
            s_axis_tkeep  = 8'hFF;
            s_axis_tlast  = 1'b0;
            s_axis_tuser  = 1'b0;
            @(posedge clk156);
            #1;
        end
        s_axis_tdata = mk(8, 3);
        eth_rst = 1'b1;
        @(posedge clk156);
        #1;
        eth_rst       = 1'b0;
        s_axis_tvalid = 1'b0;
        exp_q.delete();
        model_frames = 0;
        model_drops  = 0;
        chk_stats();
        @(posedge clk156);
        #1;
        base = out_beats;
        send_frame(9, 2, 8'h01, 1'b0);
        drain();
        chk("t5_beats", 64'(out_beats - base), 64'd2);
        chk("t5_last_data", last_data_seen, 64'h0009_0000_0000_0001);
        chk_stats();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
